// File: rtl/fetch_sequencer.sv
// Multi-cycle instruction fetch and PC sequencer feeding the instruction decoder.
// Fetches one word per instruction, strobes the decoder, waits for decode and
// execute completion, then commits the next PC or stops on halt/fault.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0100_0000,
  parameter logic [31:0] IMEM_BASE  = 32'h0100_0000,
  parameter int          IMEM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        decode,
  input  logic        id_comp,
  input  logic        halt,
  input  logic [1:0]  PCsel,
  input  logic        branch,
  input  logic        branch_taken,
  input  logic [31:0] imm,
  input  logic [31:0] alu_out,
  input  logic        exec_done,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        halted,
  output logic        fault,
  output logic [31:0] retired
);

  localparam logic [31:0] IMEM_LAST = IMEM_BASE + 32'(4 * IMEM_WORDS) - 32'd4;
  localparam logic [31:0] NOP_INSN  = 32'h0000_0013;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_WAIT_IMEM, S_DECODE, S_WAIT_ID, S_WAIT_EXEC, S_HALTED
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_pc;
  logic [31:0] r_instr;
  logic [31:0] r_retired;
  logic        r_fault;
  logic [31:0] w_pc_plus4;
  logic [31:0] w_next_pc;
  logic        w_sel_bad;
  logic        w_fetch_ok;
  logic        w_tgt_ok;

  // Word-aligned and inside the IMEM window.
  function automatic logic addr_legal(input logic [31:0] addr);
    return (addr >= IMEM_BASE) && (addr <= IMEM_LAST) && (addr[1:0] == 2'b00);
  endfunction

  // Next-PC selection from decoder/ALU results; PCsel=3 is an illegal target.
  always_comb begin
    w_pc_plus4 = r_pc + 32'd4;
    w_next_pc  = w_pc_plus4;
    w_sel_bad  = 1'b0;
    case (PCsel)
      2'd0: w_next_pc = w_pc_plus4;
      2'd1: w_next_pc = (branch && branch_taken) ? (r_pc + imm) : w_pc_plus4;
      2'd2: w_next_pc = {alu_out[31:1], 1'b0};
      default: begin
        w_next_pc = r_pc;
        w_sel_bad = 1'b1;
      end
    endcase
    w_fetch_ok = addr_legal(r_pc);
    w_tgt_ok   = !w_sel_bad && addr_legal(w_next_pc);
  end

  // Next-state logic; each input is only looked at in the state that owns it.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RST:       w_state_nxt = S_FETCH;
      S_FETCH:     w_state_nxt = w_fetch_ok ? S_WAIT_IMEM : S_HALTED;
      S_WAIT_IMEM: if (imem_valid) w_state_nxt = S_DECODE;
      S_DECODE:    w_state_nxt = S_WAIT_ID;
      S_WAIT_ID:   if (id_comp) w_state_nxt = halt ? S_HALTED : S_WAIT_EXEC;
      S_WAIT_EXEC: if (exec_done) w_state_nxt = w_tgt_ok ? S_FETCH : S_HALTED;
      S_HALTED:    w_state_nxt = S_HALTED;
      default:     w_state_nxt = S_HALTED;
    endcase
  end

  // State, PC, instruction latch, fault flag and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_RST;
      r_pc      <= RESET_PC;
      r_instr   <= NOP_INSN;
      r_retired <= 32'd0;
      r_fault   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_WAIT_IMEM && imem_valid) r_instr <= imem_rdata;
      if (r_state == S_FETCH && !w_fetch_ok) r_fault <= 1'b1;
      if (r_state == S_WAIT_EXEC && exec_done) begin
        r_retired <= r_retired + 32'd1;
        if (w_tgt_ok) r_pc <= w_next_pc;
        else          r_fault <= 1'b1;
      end
    end
  end

  assign imem_req    = (r_state == S_FETCH) && w_fetch_ok;
  assign imem_addr   = r_pc;
  assign instruction = r_instr;
  assign decode      = (r_state == S_DECODE);
  assign pc          = r_pc;
  assign pc_plus4    = w_pc_plus4;
  assign halted      = (r_state == S_HALTED);
  assign fault       = r_fault;
  assign retired     = r_retired;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed testbench for fetch_sequencer: walks instructions through the
// fetch/decode/execute handshake and checks PC, retire count, halt and faults.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        decode;
  logic        id_comp;
  logic        halt;
  logic [1:0]  PCsel;
  logic        branch;
  logic        branch_taken;
  logic [31:0] imm;
  logic [31:0] alu_out;
  logic        exec_done;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        halted;
  logic        fault;
  logic [31:0] retired;

  int checks = 0;
  int failures = 0;

  fetch_sequencer dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_rdata(imem_rdata), .instruction(instruction),
    .decode(decode), .id_comp(id_comp), .halt(halt), .PCsel(PCsel),
    .branch(branch), .branch_taken(branch_taken), .imm(imm), .alu_out(alu_out),
    .exec_done(exec_done), .pc(pc), .pc_plus4(pc_plus4), .halted(halted),
    .fault(fault), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; everything is driven and sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    imem_valid = 0; imem_rdata = 0; id_comp = 0; halt = 0; PCsel = 0;
    branch = 0; branch_taken = 0; imm = 0; alu_out = 0; exec_done = 0;
  endtask

  // Reset, release, and step into FETCH.
  task automatic do_reset();
    idle_inputs();
    #2 rst = 1;
    #1;
    check("rst_pc", pc, 32'h0100_0000);
    check("rst_req", {31'd0, imem_req}, 0);
    check("rst_instr", instruction, 32'h0000_0013);
    check("rst_retired", retired, 0);
    check("rst_flags", {29'd0, decode, halted, fault}, 0);
    @(negedge clk) rst = 0;
    tick();
  endtask

  // Entered in FETCH. Runs one instruction through; returns after the
  // exec_done edge (or after the id_comp edge when halting).
  task automatic run_instr(input logic [31:0] word, input logic hlt, input logic [1:0] sel,
                           input logic br, input logic tk, input logic [31:0] im,
                           input logic [31:0] alu, input logic [31:0] exp_pc4);
    check("fetch_req", {31'd0, imem_req}, 1);
    tick();
    check("req_one_cycle", {31'd0, imem_req}, 0);
    imem_valid = 1; imem_rdata = word;
    tick();
    imem_valid = 0; imem_rdata = 0;
    check("decode_hi", {31'd0, decode}, 1);
    check("instr", instruction, word);
    tick();
    check("decode_lo", {31'd0, decode}, 0);
    id_comp = 1; halt = hlt;
    tick();
    id_comp = 0; halt = 0;
    if (hlt) return;
    PCsel = sel; branch = br; branch_taken = tk; imm = im; alu_out = alu; exec_done = 1;
    check("pc_plus4", pc_plus4, exp_pc4);
    tick();
    idle_inputs();
  endtask

  // Stopped: no requests, no strobes, pc/retired frozen despite stray pulses.
  task automatic check_frozen(input logic [31:0] exp_pc, input logic [31:0] exp_ret,
                              input logic exp_fault);
    for (int i = 0; i < 3; i++) begin
      id_comp = (i == 0); exec_done = (i == 1); imem_valid = 1; PCsel = 2'd0;
      check("frz_req", {31'd0, imem_req}, 0);
      check("frz_halted", {31'd0, halted}, 1);
      check("frz_fault", {31'd0, fault}, {31'd0, exp_fault});
      check("frz_pc", pc, exp_pc);
      check("frz_ret", retired, exp_ret);
      check("frz_decode", {31'd0, decode}, 0);
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    rst = 0;
    idle_inputs();

    // Reset and basic sequential fetch
    do_reset();
    check("first_addr", imem_addr, 32'h0100_0000);
    run_instr(32'h0000_0093, 0, 2'd0, 0, 0, 0, 0, 32'h0100_0004);
    check("seq_pc", pc, 32'h0100_0004);
    check("seq_ret", retired, 1);
    check("seq_addr", imem_addr, 32'h0100_0004);

    // Jump to 0x0100_0010, then taken branch back by 8
    run_instr(32'h0000_0067, 0, 2'd2, 0, 0, 0, 32'h0100_0010, 32'h0100_0008);
    check("jmp_pc", pc, 32'h0100_0010);
    run_instr(32'h0000_0063, 0, 2'd1, 1, 1, 32'hFFFF_FFF8, 0, 32'h0100_0014);
    check("br_taken_pc", pc, 32'h0100_0008);
    check("br_taken_ret", retired, 3);

    // Back to 0x0100_0010, branch not taken
    run_instr(32'h0000_0067, 0, 2'd2, 0, 0, 0, 32'h0100_0010, 32'h0100_000C);
    run_instr(32'h0000_0063, 0, 2'd1, 1, 0, 32'hFFFF_FFF8, 0, 32'h0100_0014);
    check("br_nt_pc", pc, 32'h0100_0014);

    // PCsel=1 with branch flag clear falls through even if compare is true
    run_instr(32'h0000_0063, 0, 2'd1, 0, 1, 32'h0000_0100, 0, 32'h0100_0018);
    check("br_noflag_pc", pc, 32'h0100_0018);

    // JALR clears bit 0 of the target
    run_instr(32'h0000_0067, 0, 2'd2, 0, 0, 0, 32'h0100_0021, 32'h0100_001C);
    check("jalr_pc", pc, 32'h0100_0020);
    check("jalr_ret", retired, 7);

    // Misaligned target faults: pc held, retired still counted
    run_instr(32'h0000_0067, 0, 2'd2, 0, 0, 0, 32'h0100_0022, 32'h0100_0024);
    check_frozen(32'h0100_0020, 8, 1);

    // Fall off the end of IMEM
    do_reset();
    run_instr(32'h0000_0067, 0, 2'd2, 0, 0, 0, 32'h0100_0FFC, 32'h0100_0004);
    check("last_pc", pc, 32'h0100_0FFC);
    run_instr(32'h0000_0013, 0, 2'd0, 0, 0, 0, 0, 32'h0100_1000);
    check_frozen(32'h0100_0FFC, 2, 1);

    // PCsel=3 is illegal
    do_reset();
    run_instr(32'h0000_0013, 0, 2'd3, 0, 0, 0, 0, 32'h0100_0004);
    check_frozen(32'h0100_0000, 1, 1);

    // ECALL halt: no fault, no retire
    do_reset();
    run_instr(32'h0000_0073, 1, 2'd0, 0, 0, 0, 0, 32'h0100_0004);
    check("halt_instr", instruction, 32'h0000_0073);
    check_frozen(32'h0100_0000, 0, 0);

    // Async reset while waiting on IMEM, with a stale response afterwards
    do_reset();
    run_instr(32'h0000_0093, 0, 2'd0, 0, 0, 0, 0, 32'h0100_0004);
    tick();
    #2 rst = 1;
    #1;
    check("arst_pc", pc, 32'h0100_0000);
    check("arst_ret", retired, 0);
    check("arst_instr", instruction, 32'h0000_0013);
    check("arst_req", {31'd0, imem_req}, 0);
    @(negedge clk) rst = 0;
    imem_valid = 1; imem_rdata = 32'hDEAD_BEEF;
    tick();
    check("arst_refetch_req", {31'd0, imem_req}, 1);
    check("arst_refetch_addr", imem_addr, 32'h0100_0000);
    tick();
    idle_inputs();
    check("arst_stale_instr", instruction, 32'h0000_0013);
    tick();
    check("arst_no_decode", {31'd0, decode}, 0);
    check("arst_instr_hold", instruction, 32'h0000_0013);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got 0x%08h expected 0x%08h", 32'd0, 32'd1);
    $fatal(1, "timeout");
  end

endmodule
